// File: rtl/parking_pkg.sv
// Shared types and sizing helpers for the parking entrance front end.
package parking_pkg;

  localparam int unsigned DEFAULT_DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GET_D1 = 2'd1,
    ST_GET_D2 = 2'd2,
    ST_HOLD   = 2'd3
  } entry_state_e;

  // Bits needed to count from 0 up to max_val inclusive (minimum 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) <= max_val)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/parking_debounce.sv
// Two-flop synchroniser plus stability counter; the debounced level register
// lives in the parent, which feeds it back and registers level_next_c.
module parking_debounce
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic level,
  output logic level_next_c
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive disagreeing samples; flip the level on the last one.
  always_comb begin
    cnt_d        = '0;
    level_next_c = level;
    if (sync_2 != level) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_next_c = ~level;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/parking_entry_frontend.sv
// Sensor/keypad front end: debounces inputs and assembles a two-digit entry
// for parking_system, with clear and idle-timeout handling.
module parking_entry_frontend
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned DIGIT_W         = DEFAULT_DIGIT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sensor_entrance_raw,
  input  logic               sensor_exit_raw,
  input  logic               key_press_raw,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_clear,
  output logic               sensor_entrance,
  output logic               sensor_exit,
  output logic [DIGIT_W-1:0] password_1,
  output logic [DIGIT_W-1:0] password_2,
  output logic               password_valid,
  output logic               entry_timeout
);

  localparam int unsigned TCNT_W = cnt_width(TIMEOUT_CYCLES - 1);

  logic               entrance_next_c;
  logic               exit_next_c;
  logic               key_next_c;
  logic               key_level;
  logic               key_event;
  entry_state_e       state_q;
  entry_state_e       state_d;
  logic [DIGIT_W-1:0] d1_q;
  logic [DIGIT_W-1:0] d1_d;
  logic [DIGIT_W-1:0] pw1_d;
  logic [DIGIT_W-1:0] pw2_d;
  logic               valid_d;
  logic               timeout_d;
  logic [TCNT_W-1:0]  tcnt_q;
  logic [TCNT_W-1:0]  tcnt_d;
  logic               in_entry;
  logic               tmo_hit;

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_entrance (
    .clk(clk), .reset_n(reset_n), .raw(sensor_entrance_raw),
    .level(sensor_entrance), .level_next_c(entrance_next_c)
  );

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
    .clk(clk), .reset_n(reset_n), .raw(sensor_exit_raw),
    .level(sensor_exit), .level_next_c(exit_next_c)
  );

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_key (
    .clk(clk), .reset_n(reset_n), .raw(key_press_raw),
    .level(key_level), .level_next_c(key_next_c)
  );

  assign in_entry = (state_q == ST_GET_D1) || (state_q == ST_GET_D2);
  assign tmo_hit  = in_entry && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

  // Next state and outputs; the entrance uses its next level so the entry
  // collapses on the same edge the debounced sensor falls.
  always_comb begin
    state_d   = state_q;
    d1_d      = d1_q;
    pw1_d     = password_1;
    pw2_d     = password_2;
    valid_d   = password_valid;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (entrance_next_c) state_d = ST_GET_D1;
    end else if (!entrance_next_c) begin
      state_d = ST_IDLE;
      pw1_d   = '0;
      pw2_d   = '0;
      valid_d = 1'b0;
    end else if (key_clear) begin
      state_d = ST_GET_D1;
      pw1_d   = '0;
      pw2_d   = '0;
      valid_d = 1'b0;
    end else if (tmo_hit) begin
      state_d   = ST_GET_D1;
      pw1_d     = '0;
      pw2_d     = '0;
      valid_d   = 1'b0;
      timeout_d = 1'b1;
    end else if (key_event) begin
      case (state_q)
        ST_GET_D1: begin
          d1_d    = key_digit;
          state_d = ST_GET_D2;
        end
        ST_GET_D2: begin
          pw1_d   = d1_q;
          pw2_d   = key_digit;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
        default: begin
          d1_d    = key_digit;
          pw1_d   = '0;
          pw2_d   = '0;
          valid_d = 1'b0;
          state_d = ST_GET_D2;
        end
      endcase
    end
  end

  // Idle timer: restarts on any state (re)entry or keypress, saturates otherwise.
  always_comb begin
    tcnt_d = '0;
    if (in_entry && (state_d == state_q) && !key_event && !key_clear && !tmo_hit) begin
      tcnt_d = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) ? tcnt_q : tcnt_q + TCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sensor_entrance <= 1'b0;
      sensor_exit     <= 1'b0;
      key_level       <= 1'b0;
      key_event       <= 1'b0;
      state_q         <= ST_IDLE;
      d1_q            <= '0;
      tcnt_q          <= '0;
      password_1      <= '0;
      password_2      <= '0;
      password_valid  <= 1'b0;
      entry_timeout   <= 1'b0;
    end else begin
      sensor_entrance <= entrance_next_c;
      sensor_exit     <= exit_next_c;
      key_level       <= key_next_c;
      key_event       <= key_next_c & ~key_level;
      state_q         <= state_d;
      d1_q            <= d1_d;
      tcnt_q          <= tcnt_d;
      password_1      <= pw1_d;
      password_2      <= pw2_d;
      password_valid  <= valid_d;
      entry_timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_parking_entry_frontend.sv
// Directed bench for parking_entry_frontend (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_parking_entry_frontend;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor_entrance_raw = 1'b0;
  logic       sensor_exit_raw = 1'b0;
  logic       key_press_raw = 1'b0;
  logic [1:0] key_digit = 2'd0;
  logic       key_clear = 1'b0;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       password_valid;
  logic       entry_timeout;

  int errors = 0;
  int checks = 0;

  parking_entry_frontend #(
    .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16), .DIGIT_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sensor_entrance_raw(sensor_entrance_raw), .sensor_exit_raw(sensor_exit_raw),
    .key_press_raw(key_press_raw), .key_digit(key_digit), .key_clear(key_clear),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .password_1(password_1), .password_2(password_2),
    .password_valid(password_valid), .entry_timeout(entry_timeout)
  );

  always #5 clk = ~clk;

  // Bouncy press: 1 high, 1 low, then 6 stable high cycles; returns with the
  // debounced key just risen, i.e. one edge before the digit is taken.
  task automatic press(input logic [1:0] d);
    key_digit = d;
    key_press_raw = 1'b1;
    @(negedge clk);
    key_press_raw = 1'b0;
    @(negedge clk);
    key_press_raw = 1'b1;
    repeat (6) @(negedge clk);
    key_press_raw = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic seen;
    seen = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sensor_entrance_raw = i[0];
      sensor_exit_raw = ~i[0];
      key_press_raw = i[1];
      @(negedge clk);
      seen |= sensor_entrance | sensor_exit | (|password_1) | (|password_2) | password_valid | entry_timeout;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_held: outputs seen %b, want 0", seen); end
    sensor_entrance_raw = 1'b0; sensor_exit_raw = 1'b0; key_press_raw = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= sensor_entrance | sensor_exit | (|password_1) | (|password_2) | password_valid | entry_timeout;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_release: outputs seen %b, want 0", seen); end
  endtask

  task automatic test_exit();
    sensor_exit_raw = 1'b1;
    gap(5);
    checks++; if (sensor_exit !== 1'b0) begin errors++; $display("FAIL exit_early: got %b want 0", sensor_exit); end
    gap(1);
    checks++; if (sensor_exit !== 1'b1) begin errors++; $display("FAIL exit_rise: got %b want 1", sensor_exit); end
    checks++; if (sensor_entrance !== 1'b0) begin errors++; $display("FAIL exit_isolated: entrance %b want 0", sensor_entrance); end
    sensor_exit_raw = 1'b0;
    gap(6);
    checks++; if (sensor_exit !== 1'b0) begin errors++; $display("FAIL exit_fall: got %b want 0", sensor_exit); end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    sensor_entrance_raw = 1'b1;
    gap(3);
    sensor_entrance_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= sensor_entrance;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch: entrance seen %b want 0", seen); end
    sensor_entrance_raw = 1'b1;
    gap(5);
    checks++; if (sensor_entrance !== 1'b0) begin errors++; $display("FAIL entr_5th: got %b want 0", sensor_entrance); end
    gap(1);
    checks++; if (sensor_entrance !== 1'b1) begin errors++; $display("FAIL entr_6th: got %b want 1", sensor_entrance); end
  endtask

  task automatic test_two_digits();
    logic bad;
    bad = 1'b0;
    press(2'd1);
    gap(5);
    press(2'd2);
    checks++; if (password_valid !== 1'b0) begin errors++; $display("FAIL d2_pre: valid %b want 0", password_valid); end
    gap(1);
    checks++; if (password_valid !== 1'b1) begin errors++; $display("FAIL d2_valid: got %b want 1", password_valid); end
    checks++; if (password_1 !== 2'd1) begin errors++; $display("FAIL d2_pw1: got %0d want 1", password_1); end
    checks++; if (password_2 !== 2'd2) begin errors++; $display("FAIL d2_pw2: got %0d want 2", password_2); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (password_valid !== 1'b1 || password_1 !== 2'd1 || password_2 !== 2'd2) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hold_stable: changed %b want 0", bad); end
  endtask

  task automatic test_drop();
    sensor_entrance_raw = 1'b0;
    gap(5);
    checks++; if (password_valid !== 1'b1) begin errors++; $display("FAIL drop_pre: valid %b want 1", password_valid); end
    gap(1);
    checks++; if (sensor_entrance !== 1'b0) begin errors++; $display("FAIL drop_entr: got %b want 0", sensor_entrance); end
    checks++; if ({password_valid, password_1, password_2} !== 5'd0) begin
      errors++; $display("FAIL drop_clear: valid/pw1/pw2 %b/%0d/%0d want 0/0/0", password_valid, password_1, password_2);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    int first;
    logic bad;
    pulses = 0; first = -1; bad = 1'b0;
    sensor_entrance_raw = 1'b1;
    gap(6);
    press(2'd1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (entry_timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (password_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL tmo_count: got %0d want 1", pulses); end
    checks++; if (first !== 17) begin errors++; $display("FAIL tmo_time: got %0d want 17", first); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL tmo_valid: valid seen %b want 0", bad); end
    press(2'd3);
    gap(5);
    press(2'd0);
    gap(1);
    checks++; if ({password_valid, password_1, password_2} !== {1'b1, 2'd3, 2'd0}) begin
      errors++; $display("FAIL tmo_reentry: valid/pw1/pw2 %b/%0d/%0d want 1/3/0", password_valid, password_1, password_2);
    end
  endtask

  task automatic test_hold_rekey();
    gap(4);
    press(2'd0);
    checks++; if (password_valid !== 1'b1) begin errors++; $display("FAIL rekey_pre: valid %b want 1", password_valid); end
    gap(1);
    checks++; if ({password_valid, password_1, password_2} !== 5'd0) begin
      errors++; $display("FAIL rekey_clear: valid/pw1/pw2 %b/%0d/%0d want 0/0/0", password_valid, password_1, password_2);
    end
    gap(4);
    press(2'd3);
    gap(1);
    checks++; if ({password_valid, password_1, password_2} !== {1'b1, 2'd0, 2'd3}) begin
      errors++; $display("FAIL rekey_pw: valid/pw1/pw2 %b/%0d/%0d want 1/0/3", password_valid, password_1, password_2);
    end
  endtask

  task automatic test_clear_wins();
    gap(4);
    press(2'd1);
    key_clear = 1'b1;
    gap(1);
    key_clear = 1'b0;
    checks++; if ({password_valid, password_1, password_2} !== 5'd0) begin
      errors++; $display("FAIL clr_outputs: valid/pw1/pw2 %b/%0d/%0d want 0/0/0", password_valid, password_1, password_2);
    end
    gap(4);
    press(2'd2);
    gap(1);
    checks++; if (password_valid !== 1'b0) begin errors++; $display("FAIL clr_state: valid %b want 0 after first digit", password_valid); end
    gap(4);
    press(2'd1);
    gap(1);
    checks++; if ({password_valid, password_1, password_2} !== {1'b1, 2'd2, 2'd1}) begin
      errors++; $display("FAIL clr_entry: valid/pw1/pw2 %b/%0d/%0d want 1/2/1", password_valid, password_1, password_2);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({sensor_entrance, password_valid, password_1, password_2, entry_timeout} !== 7'd0) begin
      errors++; $display("FAIL async_reset: entr/valid/pw1/pw2 %b/%b/%0d/%0d want 0/0/0/0",
                         sensor_entrance, password_valid, password_1, password_2);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_exit();
    test_glitch();
    test_two_digits();
    test_drop();
    test_timeout();
    test_hold_rekey();
    test_clear_wins();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
